start_screen_sequencer: RTL and testbench



---
 rtl/start_screen_sequencer_pkg.sv | 15 +
 rtl/start_screen_sequencer_color_scaler.sv | 10 +
 rtl/start_screen_sequencer.sv | 156 +++++++++++++++
 tb/tb_start_screen_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/start_screen_sequencer_pkg.sv
// start_screen_sequencer_pkg: display constants and screen states shared by the start screen sequencer
package DisplayPkg;
    localparam int unsigned SVGA_WIDTH  = 800;
    localparam int unsigned SVGA_HEIGHT = 600;
    localparam logic [23:0] BG_COLOR    = 24'h000000;
    localparam logic [4:0]  BRIGHT_MAX  = 5'd16;

    typedef enum logic [2:0] {
        FADE_IN    = 3'd0,
        HOLD       = 3'd1,
        WAIT_START = 3'd2,
        FADE_OUT   = 3'd3,
        GAME       = 3'd4
    } screen_state_t;
endpackage

// File: rtl/start_screen_sequencer_color_scaler.sv
// color_scaler: per-channel (ch*brightness)>>4 on a 24-bit RGB value; brightness 16 is unity gain
module color_scaler (
    input  logic [23:0] color,
    input  logic [4:0]  bright,
    output logic [23:0] scaled
);
    for (genvar c = 0; c < 3; c++) begin : g_ch
        assign scaled[8*c +: 8] = 8'((13'(color[8*c +: 8]) * 13'(bright)) >> 4);
    end
endmodule

// File: rtl/start_screen_sequencer.sv
// start_screen_sequencer: frame-synchronous logo fade/hold/prompt/fade-out sequencer handing over to gameplay
// Optional feature: START_SKIP_EN lets a press during FADE_IN/HOLD jump straight to WAIT_START.
module start_screen_sequencer
    import DisplayPkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES      = 60,
    parameter int unsigned BLINK_FRAMES     = 30
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [9:0]  VGA_row,
    input  logic [9:0]  VGA_col,
    input  logic        start_btn,
    input  logic        game_over,
    input  logic [23:0] logo_color,
    input  logic        logo_active,
    input  logic [23:0] game_color,
    output logic [23:0] output_color,
    output logic        prompt_visible,
    output logic        game_start,
    output logic [2:0]  screen_state
);
`ifdef START_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [15:0] FADE_LAST  = 16'(FADE_STEP_FRAMES - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_FRAMES - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    screen_state_t state_q, state_d;
    logic [4:0]  bright_q, bright_d;
    logic [15:0] cnt_q, cnt_d;
    logic        prompt_q, prompt_d;
    logic        gs_q, gs_d;
    logic        pend_q, pend_d;
    logic        go_q, go_d;
    logic        btn_q, btn_d;
    logic        fb, pend, go_seen;
    logic [23:0] scaled;

    assign fb      = (VGA_row == 10'(SVGA_HEIGHT - 1)) && (VGA_col == 10'(SVGA_WIDTH - 1));
    assign pend    = pend_q | (start_btn & ~btn_q);
    assign go_seen = go_q | (game_over && state_q == GAME);

    color_scaler u_scaler (
        .color  (logo_color),
        .bright (bright_q),
        .scaled (scaled)
    );

    assign output_color   = (state_q == GAME) ? game_color : logo_active ? scaled : BG_COLOR;
    assign prompt_visible = prompt_q;
    assign game_start     = gs_q;
    assign screen_state   = state_q;

    // Register all sequencer state; everything returns to its idle fade-in value on reset
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= FADE_IN;
            bright_q <= '0;
            cnt_q    <= '0;
            prompt_q <= 1'b0;
            gs_q     <= 1'b0;
            pend_q   <= 1'b0;
            go_q     <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            cnt_q    <= cnt_d;
            prompt_q <= prompt_d;
            gs_q     <= gs_d;
            pend_q   <= pend_d;
            go_q     <= go_d;
            btn_q    <= btn_d;
        end
    end

    // Next-state logic: latches press/game-over events between frames and steps the FSM only at frame boundaries
    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        cnt_d    = cnt_q;
        prompt_d = prompt_q;
        gs_d     = 1'b0;
        btn_d    = start_btn;
        pend_d   = fb ? 1'b0 : pend;
        go_d     = fb ? 1'b0 : go_seen;
        if (fb) begin
            case (state_q)
                FADE_IN: begin
                    if (SKIP && pend) begin
                        state_d  = WAIT_START;
                        bright_d = BRIGHT_MAX;
                        prompt_d = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q == FADE_LAST) begin
                        cnt_d    = '0;
                        bright_d = bright_q + 5'd1;
                        state_d  = (bright_q == BRIGHT_MAX - 5'd1) ? HOLD : FADE_IN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                HOLD: begin
                    if ((SKIP && pend) || cnt_q == HOLD_LAST) begin
                        state_d  = WAIT_START;
                        prompt_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                WAIT_START: begin
                    if (pend) begin
                        state_d  = FADE_OUT;
                        prompt_d = 1'b0;
                        cnt_d    = '0;
                    end else if (cnt_q == BLINK_LAST) begin
                        prompt_d = ~prompt_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                FADE_OUT: begin
                    if (cnt_q == FADE_LAST) begin
                        cnt_d    = '0;
                        bright_d = bright_q - 5'd1;
                        state_d  = (bright_q == 5'd1) ? GAME : FADE_OUT;
                        gs_d     = (bright_q == 5'd1);
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                GAME: begin
                    if (go_seen) begin
                        state_d  = FADE_IN;
                        bright_d = '0;
                        cnt_d    = '0;
                        prompt_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = FADE_IN;
                    bright_d = '0;
                    cnt_d    = '0;
                    prompt_d = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_start_screen_sequencer.sv
// tb_start_screen_sequencer: directed self-checking bench for start_screen_sequencer
module tb_start_screen_sequencer;
    import DisplayPkg::*;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [9:0]  VGA_row, VGA_col;
    logic        start_btn, game_over, logo_active;
    logic [23:0] logo_color, game_color, output_color;
    logic        prompt_visible, game_start;
    logic [2:0]  screen_state;
    int          vectors = 0;
    int          miscompares = 0;
    int          gs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (game_start === 1'b1) gs_cnt <= gs_cnt + 1;

    start_screen_sequencer #(
        .FADE_STEP_FRAMES (1),
        .HOLD_FRAMES      (2),
        .BLINK_FRAMES     (2)
    ) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .VGA_row        (VGA_row),
        .VGA_col        (VGA_col),
        .start_btn      (start_btn),
        .game_over      (game_over),
        .logo_color     (logo_color),
        .logo_active    (logo_active),
        .game_color     (game_color),
        .output_color   (output_color),
        .prompt_visible (prompt_visible),
        .game_start     (game_start),
        .screen_state   (screen_state)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fb(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            VGA_row = 10'd599;
            VGA_col = 10'd799;
            @(negedge clk);
            VGA_row = 10'd10;
            VGA_col = 10'd10;
        end
    endtask

    task automatic fb_press();
        @(negedge clk);
        VGA_row   = 10'd599;
        VGA_col   = 10'd799;
        start_btn = 1'b1;
        @(negedge clk);
        VGA_row   = 10'd10;
        VGA_col   = 10'd10;
        start_btn = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0; VGA_row = 10'd10; VGA_col = 10'd10;
        start_btn = 1'b0; game_over = 1'b0; logo_active = 1'b1;
        logo_color = 24'hFF8040; game_color = 24'h123456;
        repeat (3) @(negedge clk);
        check("rst_state", 24'(screen_state), 24'(FADE_IN));
        check("rst_color", output_color, 24'h000000);
        check("rst_prompt", 24'(prompt_visible), 24'd0);
        check("rst_gs", 24'(game_start), 24'd0);
        rst_l = 1'b1;

        fb(8);
        check("fade_b8", output_color, 24'h7F4020);
        check("fade_b8_state", 24'(screen_state), 24'(FADE_IN));
        fb(8);
        check("fade_b16", output_color, 24'hFF8040);
        check("hold_state", 24'(screen_state), 24'(HOLD));
        fb(2);
        check("wait_state", 24'(screen_state), 24'(WAIT_START));
        check("prompt_on", 24'(prompt_visible), 24'd1);
        fb(2);
        check("prompt_off", 24'(prompt_visible), 24'd0);
        fb(2);
        check("prompt_on2", 24'(prompt_visible), 24'd1);

        fb_press();
        check("fo_state", 24'(screen_state), 24'(FADE_OUT));
        check("fo_prompt", 24'(prompt_visible), 24'd0);
        fb(15);
        check("fo_b1", output_color, 24'h0F0804);
        check("fo_b1_state", 24'(screen_state), 24'(FADE_OUT));
        check("fo_no_gs", 24'(game_start), 24'd0);
        fb(1);
        check("gs_high", 24'(game_start), 24'd1);
        check("game_state", 24'(screen_state), 24'(GAME));
        check("game_color", output_color, 24'h123456);
        @(negedge clk);
        check("gs_low", 24'(game_start), 24'd0);

        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        repeat (3) @(negedge clk);
        check("go_wait_state", 24'(screen_state), 24'(GAME));
        fb(1);
        check("go_state", 24'(screen_state), 24'(FADE_IN));
        check("go_black", output_color, 24'h000000);

        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        fb(1);
        check("go_ignored", 24'(screen_state), 24'(FADE_IN));
        check("fi_b1", output_color, 24'h0F0804);
        fb(2);
        check("fi_b3", output_color, 24'h2F180C);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        fb(1);
`ifdef START_SKIP_EN
        check("skip_state", 24'(screen_state), 24'(WAIT_START));
        check("skip_color", output_color, 24'hFF8040);
        check("skip_prompt", 24'(prompt_visible), 24'd1);
`else
        check("noskip_state", 24'(screen_state), 24'(FADE_IN));
        check("noskip_b4", output_color, 24'h3F2010);
`endif

        @(negedge clk); rst_l = 1'b0;
        @(negedge clk); rst_l = 1'b1;
        fb(18);
        check("r2_wait", 24'(screen_state), 24'(WAIT_START));
        fb_press();
        fb(7);
        check("r2_b9", output_color, 24'h8F4824);
        check("r2_fo", 24'(screen_state), 24'(FADE_OUT));
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("arst_state", 24'(screen_state), 24'(FADE_IN));
        check("arst_color", output_color, 24'h000000);
        check("arst_prompt", 24'(prompt_visible), 24'd0);
        @(negedge clk); rst_l = 1'b1;
        fb(3);
        check("arst_b3", output_color, 24'h2F180C);
        check("gs_once", 24'(gs_cnt), 24'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
